// File: rtl/fft_iterative_sequencer.sv
// Purpose : runs a full N-point FFT by passing one frame through a single shared
//           stage datapath LOG2N times, one pass per stage index.
// Latency : LOG2N * (1 + L) cycles from frame accept to send_val, L = datapath latency.
// Backpr. : every handshake stalls indefinitely with outputs held stable.
//
// Ports:
//   clk, reset (async, active-low)
//   recv_msg_real/imag, recv_val, recv_rdy        : input frame
//   stage_send_real/imag, stage_send_val/rdy,
//   stage_idx                                     : frame issued to stage datapath
//   stage_recv_real/imag, stage_recv_val/rdy      : stage datapath result
//   send_msg_real/imag, send_val, send_rdy        : transformed output frame
//   busy                                          : high whenever not IDLE
module fft_iterative_sequencer #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8,
  localparam int LOG2N     = $clog2(N_SAMPLES),
  localparam int IDX_W     = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg_real,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg_imag,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] stage_send_real,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] stage_send_imag,
  output logic                           stage_send_val,
  input  logic                           stage_send_rdy,
  output logic [IDX_W-1:0]               stage_idx,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] stage_recv_real,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] stage_recv_imag,
  input  logic                           stage_recv_val,
  output logic                           stage_recv_rdy,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg_real,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg_imag,
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic                           busy
);

  localparam int FW = BIT_WIDTH * N_SAMPLES;

  // DECIMAL_PT only describes the number format the stage datapath works in;
  // samples pass through here untouched. Out-of-range values leave an empty
  // marker block in the elaborated hierarchy.
  if (DECIMAL_PT < 0 || DECIMAL_PT > BIT_WIDTH) begin : g_decimal_pt_out_of_range
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDX_W-1:0] stage_idx_q, stage_idx_d;
  logic [FW-1:0]    buf_real_q, buf_real_d;
  logic [FW-1:0]    buf_imag_q, buf_imag_d;
  logic             last_stage;

  assign last_stage = (stage_idx_q == IDX_W'(LOG2N - 1));

  always_comb begin
    state_d        = state_q;
    stage_idx_d    = stage_idx_q;
    buf_real_d     = buf_real_q;
    buf_imag_d     = buf_imag_q;
    recv_rdy       = 1'b0;
    stage_send_val = 1'b0;
    stage_recv_rdy = 1'b0;
    send_val       = 1'b0;
    busy           = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        recv_rdy = 1'b1;
      end
      S_ISSUE: begin
        // Buffer is held here so the datapath sees a stable frame while stalled.
        stage_send_val = 1'b1;
        if (stage_send_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        stage_recv_rdy = 1'b1;
        if (stage_recv_val) begin
          buf_real_d = stage_recv_real;
          buf_imag_d = stage_recv_imag;
          if (last_stage) begin
            state_d = S_DONE;
          end else begin
            stage_idx_d = stage_idx_q + IDX_W'(1);
            state_d     = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        send_val = 1'b1;
        // Draining the output frame frees the buffer in the same cycle, so a new
        // frame may be taken on that edge (send_rdy -> recv_rdy is combinational).
        recv_rdy = send_rdy;
        if (send_rdy) begin
          state_d     = S_IDLE;
          stage_idx_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A frame accept overrides whatever the state branch decided.
    if (recv_val && recv_rdy) begin
      buf_real_d  = recv_msg_real;
      buf_imag_d  = recv_msg_imag;
      stage_idx_d = '0;
      state_d     = S_ISSUE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      stage_idx_q <= '0;
      buf_real_q  <= '0;
      buf_imag_q  <= '0;
    end else begin
      state_q     <= state_d;
      stage_idx_q <= stage_idx_d;
      buf_real_q  <= buf_real_d;
      buf_imag_q  <= buf_imag_d;
    end
  end

  assign stage_idx       = stage_idx_q;
  assign stage_send_real = buf_real_q;
  assign stage_send_imag = buf_imag_q;
  assign send_msg_real   = buf_real_q;
  assign send_msg_imag   = buf_imag_q;

endmodule

// File: tb/tb_fft_iterative_sequencer.sv
// Bench for fft_iterative_sequencer: a behavioural stage datapath (adds 1 to every
// real word, configurable latency and stall) plus a scoreboard of expected frames.
module tb_fft_iterative_sequencer;

  localparam int BW = 32;
  localparam int NS = 8;
  localparam int LG = 3;
  localparam int IW = 2;
  localparam int FW = BW * NS;
  localparam logic [FW-1:0] DEAD_FRAME = {NS{32'h0000DEAD}};

  logic          clk;
  logic          reset;
  logic [FW-1:0] recv_msg_real, recv_msg_imag;
  logic          recv_val, recv_rdy;
  logic [FW-1:0] stage_send_real, stage_send_imag;
  logic          stage_send_val, stage_send_rdy;
  logic [IW-1:0] stage_idx;
  logic [FW-1:0] stage_recv_real, stage_recv_imag;
  logic          stage_recv_val, stage_recv_rdy;
  logic [FW-1:0] send_msg_real, send_msg_imag;
  logic          send_val, send_rdy;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [FW-1:0] exp_re_q[$];
  logic [FW-1:0] exp_im_q[$];
  int            acc_q[$];
  int            idx_seen[$];

  // datapath model controls and state
  int            dp_en = 1;
  int            dp_lat = 2;
  int            dp_stall = 0;
  int            dp_stall_stage = -1;
  logic          stray_val = 1'b0;
  logic          dp_send_rdy, dp_recv_val;
  logic [FW-1:0] dp_re_out, dp_im_out, dp_re, dp_im;
  logic          dp_full, iss_hs, rec_hs;
  int            dp_cnt;

  assign stage_send_rdy  = (dp_en != 0) ? dp_send_rdy : 1'b0;
  assign stage_recv_val  = (dp_en != 0) ? dp_recv_val : stray_val;
  assign stage_recv_real = (dp_en != 0) ? dp_re_out : DEAD_FRAME;
  assign stage_recv_imag = (dp_en != 0) ? dp_im_out : DEAD_FRAME;

  fft_iterative_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .recv_msg_real  (recv_msg_real),
    .recv_msg_imag  (recv_msg_imag),
    .recv_val       (recv_val),
    .recv_rdy       (recv_rdy),
    .stage_send_real(stage_send_real),
    .stage_send_imag(stage_send_imag),
    .stage_send_val (stage_send_val),
    .stage_send_rdy (stage_send_rdy),
    .stage_idx      (stage_idx),
    .stage_recv_real(stage_recv_real),
    .stage_recv_imag(stage_recv_imag),
    .stage_recv_val (stage_recv_val),
    .stage_recv_rdy (stage_recv_rdy),
    .send_msg_real  (send_msg_real),
    .send_msg_imag  (send_msg_imag),
    .send_val       (send_val),
    .send_rdy       (send_rdy),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FW-1:0] ramp(input int base);
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v[i*BW +: BW] = BW'(base + i);
    return v;
  endfunction

  function automatic logic [FW-1:0] add_k(input logic [FW-1:0] v, input int k);
    logic [FW-1:0] r;
    r = v;
    for (int i = 0; i < NS; i++) r[i*BW +: BW] = v[i*BW +: BW] + BW'(k);
    return r;
  endfunction

  // Stage datapath model: decides its inputs at each falling edge from the DUT
  // state, and retires the handshakes it committed to on the previous one.
  initial begin
    dp_send_rdy = 1'b0; dp_recv_val = 1'b0;
    dp_re_out = '0; dp_im_out = '0; dp_re = '0; dp_im = '0;
    dp_full = 1'b0; iss_hs = 1'b0; rec_hs = 1'b0; dp_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || dp_en == 0) begin
        dp_full = 1'b0; iss_hs = 1'b0; rec_hs = 1'b0;
        dp_send_rdy = 1'b0; dp_recv_val = 1'b0;
      end else begin
        if (rec_hs) dp_full = 1'b0;
        if (iss_hs) begin dp_full = 1'b1; dp_cnt = dp_lat; end
        rec_hs = 1'b0; iss_hs = 1'b0; dp_recv_val = 1'b0;
        if (dp_full) begin
          dp_send_rdy = 1'b0;
          if (dp_cnt > 0) dp_cnt--;
          if (dp_cnt == 0) begin
            dp_recv_val = 1'b1; dp_re_out = dp_re; dp_im_out = dp_im;
            rec_hs = (stage_recv_rdy === 1'b1);
          end
        end else if (stage_send_val === 1'b1 && dp_stall > 0 && int'(stage_idx) == dp_stall_stage) begin
          dp_send_rdy = 1'b0;
          dp_stall--;
        end else begin
          dp_send_rdy = 1'b1;
        end
        if (stage_send_val === 1'b1 && dp_send_rdy) begin
          iss_hs = 1'b1;
          dp_re = add_k(stage_send_real, 1);
          dp_im = stage_send_imag;
          idx_seen.push_back(int'(stage_idx));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Offers a ramp frame at a falling edge and holds it until accepted.
  task automatic drive_frame(input int bre, input int bim, output int ok);
    recv_msg_real = ramp(bre);
    recv_msg_imag = ramp(bim);
    recv_val = 1'b1;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (recv_rdy === 1'b1) begin
        ok = 1;
        acc_q.push_back(cyc + 1);
        exp_re_q.push_back(ramp(bre + LG));
        exp_im_q.push_back(ramp(bim));
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    recv_val = 1'b0;
  endtask

  task automatic wait_out(output int ok, output int t);
    ok = 0; t = 0;
    for (int k = 0; k < 400; k++) begin
      if (send_val === 1'b1) begin ok = 1; t = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL por_recv_rdy got=%b exp=1", recv_rdy); end
    total++; if ({stage_send_val, stage_recv_rdy, send_val, busy} !== 4'b0000) begin
      bad++; $display("FAIL por_ctrl got=%b exp=0000", {stage_send_val, stage_recv_rdy, send_val, busy}); end
    total++; if (stage_idx !== 2'd0) begin bad++; $display("FAIL por_idx got=%0d exp=0", stage_idx); end
    total++; if (send_msg_real !== '0 || send_msg_imag !== '0 || stage_send_real !== '0) begin
      bad++; $display("FAIL por_data got=%h exp=0", send_msg_real); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (recv_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL por_release got rdy=%b busy=%b exp rdy=1 busy=0", recv_rdy, busy); end
    @(negedge clk);
  endtask

  task automatic test_single();
    int ok, t, acc;
    dp_lat = 2; send_rdy = 1'b0; idx_seen.delete();
    drive_frame(0, 100, ok);
    total++; if (ok !== 1) begin bad++; $display("FAIL single_accept got=%0d exp=1", ok); end
    wait_out(ok, t);
    total++; if (ok !== 1) begin bad++; $display("FAIL single_out_timeout got=%0d exp=1", ok); end
    acc = acc_q.pop_front();
    total++; if (t - acc !== 9) begin bad++; $display("FAIL single_latency got=%0d exp=9", t - acc); end
    total++; if (send_msg_real !== exp_re_q.pop_front()) begin bad++; $display("FAIL single_real got=%h", send_msg_real); end
    total++; if (send_msg_imag !== exp_im_q.pop_front()) begin bad++; $display("FAIL single_imag got=%h", send_msg_imag); end
    total++; if (idx_seen.size() !== 3) begin bad++; $display("FAIL single_idx_count got=%0d exp=3", idx_seen.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= idx_seen.size() || idx_seen[i] !== i) begin
        bad++; $display("FAIL single_idx_seq pos=%0d got=%0d exp=%0d", i, (i < idx_seen.size()) ? idx_seen[i] : -1, i);
      end
    end
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_back_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_dp_backpressure();
    int ok, t, acc, found;
    dp_lat = 2; dp_stall = 5; dp_stall_stage = 1; send_rdy = 1'b0;
    drive_frame(10, 200, ok);
    total++; if (ok !== 1) begin bad++; $display("FAIL dpbp_accept got=%0d exp=1", ok); end
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (stage_send_val === 1'b1 && stage_idx === 2'd1) begin found = 1; break; end
      @(negedge clk);
    end
    total++; if (found !== 1) begin bad++; $display("FAIL dpbp_stage1_issue got=%0d exp=1", found); end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (stage_send_val !== 1'b1 || stage_idx !== 2'd1 || stage_send_real !== ramp(11) || stage_send_imag !== ramp(200)) begin
        bad++; $display("FAIL dpbp_hold cyc=%0d got val=%b idx=%0d real=%h", c, stage_send_val, stage_idx, stage_send_real);
      end
      @(negedge clk);
    end
    wait_out(ok, t);
    total++; if (ok !== 1) begin bad++; $display("FAIL dpbp_out_timeout got=%0d exp=1", ok); end
    acc = acc_q.pop_front();
    total++; if (t - acc !== 14) begin bad++; $display("FAIL dpbp_latency got=%0d exp=14", t - acc); end
    total++; if (send_msg_real !== exp_re_q.pop_front()) begin bad++; $display("FAIL dpbp_real got=%h", send_msg_real); end
    total++; if (send_msg_imag !== exp_im_q.pop_front()) begin bad++; $display("FAIL dpbp_imag got=%h", send_msg_imag); end
    dp_stall_stage = -1;
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
  endtask

  task automatic test_out_backpressure();
    int ok, t, acc;
    dp_lat = 1; send_rdy = 1'b0;
    drive_frame(20, 300, ok);
    wait_out(ok, t);
    total++; if (ok !== 1) begin bad++; $display("FAIL obp_first_timeout got=%0d exp=1", ok); end
    acc = acc_q.pop_front();
    total++; if (t - acc !== 6) begin bad++; $display("FAIL obp_latency_a got=%0d exp=6", t - acc); end
    recv_msg_real = ramp(40); recv_msg_imag = ramp(400); recv_val = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (recv_rdy !== 1'b0 || send_val !== 1'b1 || send_msg_real !== exp_re_q[0] || send_msg_imag !== exp_im_q[0]) begin
        bad++; $display("FAIL obp_stall cyc=%0d got rdy=%b val=%b real=%h", c, recv_rdy, send_val, send_msg_real);
      end
      @(negedge clk);
    end
    void'(exp_re_q.pop_front());
    void'(exp_im_q.pop_front());
    send_rdy = 1'b1;
    #1;
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL obp_release_rdy got=%b exp=1", recv_rdy); end
    acc_q.push_back(cyc + 1);
    exp_re_q.push_back(ramp(40 + LG));
    exp_im_q.push_back(ramp(400));
    @(negedge clk);
    send_rdy = 1'b0; recv_val = 1'b0;
    total++;
    if (stage_send_val !== 1'b1 || stage_idx !== 2'd0 || stage_send_real !== ramp(40)) begin
      bad++; $display("FAIL obp_new_issue got val=%b idx=%0d real=%h", stage_send_val, stage_idx, stage_send_real);
    end
    wait_out(ok, t);
    total++; if (ok !== 1) begin bad++; $display("FAIL obp_second_timeout got=%0d exp=1", ok); end
    acc = acc_q.pop_front();
    total++; if (t - acc !== 6) begin bad++; $display("FAIL obp_latency_b got=%0d exp=6", t - acc); end
    total++; if (send_msg_real !== exp_re_q.pop_front()) begin bad++; $display("FAIL obp_real_b got=%h", send_msg_real); end
    total++; if (send_msg_imag !== exp_im_q.pop_front()) begin bad++; $display("FAIL obp_imag_b got=%h", send_msg_imag); end
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
  endtask

  task automatic test_stray();
    int ok, t;
    dp_en = 0; stray_val = 1'b1; send_rdy = 1'b0;
    #1;
    total++; if (stage_recv_rdy !== 1'b0) begin bad++; $display("FAIL stray_idle_rdy got=%b exp=0", stage_recv_rdy); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || recv_rdy !== 1'b1 || send_msg_real !== ramp(40 + LG)) begin
      bad++; $display("FAIL stray_idle_state got busy=%b rdy=%b real=%h", busy, recv_rdy, send_msg_real); end
    drive_frame(50, 500, ok);
    total++; if (ok !== 1) begin bad++; $display("FAIL stray_accept got=%0d exp=1", ok); end
    for (int c = 0; c < 2; c++) begin
      total++;
      if (stage_send_val !== 1'b1 || stage_recv_rdy !== 1'b0 || stage_send_real !== ramp(50)) begin
        bad++; $display("FAIL stray_issue cyc=%0d got val=%b rdy=%b real=%h", c, stage_send_val, stage_recv_rdy, stage_send_real);
      end
      @(negedge clk);
    end
    stray_val = 1'b0; dp_en = 1;
    wait_out(ok, t);
    total++; if (ok !== 1) begin bad++; $display("FAIL stray_out_timeout got=%0d exp=1", ok); end
    void'(acc_q.pop_front());
    total++; if (send_msg_real !== exp_re_q.pop_front()) begin bad++; $display("FAIL stray_real got=%h", send_msg_real); end
    total++; if (send_msg_imag !== exp_im_q.pop_front()) begin bad++; $display("FAIL stray_imag got=%h", send_msg_imag); end
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
  endtask

  task automatic test_mid_reset();
    int ok, found;
    dp_lat = 2; send_rdy = 1'b0;
    drive_frame(60, 600, ok);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (stage_recv_rdy === 1'b1 && stage_idx === 2'd1) begin found = 1; break; end
      @(negedge clk);
    end
    total++; if (found !== 1) begin bad++; $display("FAIL mrst_reach_wait got=%0d exp=1", found); end
    #2 reset = 1'b0;
    #1;
    total++; if (recv_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mrst_ctrl got rdy=%b busy=%b exp rdy=1 busy=0", recv_rdy, busy); end
    total++; if ({stage_send_val, stage_recv_rdy, send_val} !== 3'b000 || stage_idx !== 2'd0) begin
      bad++; $display("FAIL mrst_outs got vals=%b idx=%0d exp 000/0", {stage_send_val, stage_recv_rdy, send_val}, stage_idx); end
    total++; if (send_msg_real !== '0 || stage_send_imag !== '0) begin
      bad++; $display("FAIL mrst_buffer got real=%h exp=0", send_msg_real); end
    acc_q.delete(); exp_re_q.delete(); exp_im_q.delete();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (recv_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mrst_release got rdy=%b busy=%b exp rdy=1 busy=0", recv_rdy, busy); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ok_d[3];
    int acc_hist[3];
    dp_lat = 1; send_rdy = 1'b1;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          int okf;
          drive_frame(70 + 10 * f, 700 + 10 * f, okf);
          ok_d[f] = okf;
        end
      end
      begin
        for (int f = 0; f < 3; f++) begin
          int okm, tm;
          wait_out(okm, tm);
          total++; if (okm !== 1) begin bad++; $display("FAIL stream_out_timeout frame=%0d", f); end
          acc_hist[f] = acc_q.pop_front();
          total++; if (tm - acc_hist[f] !== 6) begin bad++; $display("FAIL stream_latency frame=%0d got=%0d exp=6", f, tm - acc_hist[f]); end
          total++; if (send_msg_real !== exp_re_q.pop_front()) begin bad++; $display("FAIL stream_real frame=%0d got=%h", f, send_msg_real); end
          total++; if (send_msg_imag !== exp_im_q.pop_front()) begin bad++; $display("FAIL stream_imag frame=%0d got=%h", f, send_msg_imag); end
          @(negedge clk);
        end
      end
    join
    for (int f = 0; f < 3; f++) begin
      total++; if (ok_d[f] !== 1) begin bad++; $display("FAIL stream_accept frame=%0d got=%0d exp=1", f, ok_d[f]); end
    end
    for (int f = 1; f < 3; f++) begin
      total++; if (acc_hist[f] - acc_hist[f-1] !== 7) begin
        bad++; $display("FAIL stream_spacing frame=%0d got=%0d exp=7", f, acc_hist[f] - acc_hist[f-1]); end
    end
    send_rdy = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stream_end_idle got busy=%b exp=0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    recv_msg_real = '0; recv_msg_imag = '0; recv_val = 1'b0; send_rdy = 1'b0;
    test_reset();
    test_single();
    test_dp_backpressure();
    test_out_backpressure();
    test_stray();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
